// File: rtl/mac_layer_seq.sv
// mac_layer_seq: runs one dense layer of N_OUT neurons through a single
// external 1-cycle-latency mac. Rows and biases are loaded through the cfg
// port, then each input vector gets N_OUT back-to-back issue cycles. Results
// are collected in order and offered as one flat word.
// Optional feature: define MAC_SEQ_RELU_EN to store negative results as 0.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. The input side holds in_ready=1 only in IDLE, and the result side
// holds out_valid=1 with y_flat/sat_any stable until out_ready is seen.
module mac_layer_seq #(
    parameter int N_FEATURES = 3,
    parameter int N_OUT      = 4,
    parameter int WIDTH      = 32,
    parameter int FRACTION   = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          cfg_we,
    input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0]  cfg_addr,
    input  logic [WIDTH*N_FEATURES-1:0]                   cfg_w_flat,
    input  logic [WIDTH-1:0]                              cfg_b,
    output logic                                          cfg_err,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [WIDTH*N_FEATURES-1:0]                   x_flat,
    output logic                                          mac_valid_i,
    output logic [WIDTH*N_FEATURES-1:0]                   mac_x_flat,
    output logic [WIDTH*N_FEATURES-1:0]                   mac_w_flat,
    output logic [WIDTH-1:0]                              mac_b,
    input  logic                                          mac_valid_o,
    input  logic [WIDTH-1:0]                              mac_yhat,
    input  logic                                          mac_sat,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [WIDTH*N_OUT-1:0]                        y_flat,
    output logic                                          sat_any,
    output logic                                          busy
);

    localparam int AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IW = $clog2(N_OUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IW-1:0] N_OUT_I = IW'(N_OUT);
    localparam logic [IW-1:0] LAST_I  = IW'(N_OUT - 1);
    localparam logic [AW:0]   N_OUT_A = (AW + 1)'(N_OUT);

    // The mac owns the binary point; this block only needs a sane setting.
    if (N_OUT < 1 || FRACTION >= WIDTH) begin : g_param_check
        $error("mac_layer_seq: N_OUT must be >= 1 and FRACTION < WIDTH");
    end

    logic [1:0]                      state;
    logic [IW-1:0]                   issue_idx;
    logic [IW-1:0]                   cap_idx;
    logic [WIDTH*N_FEATURES-1:0]     x_reg;
    logic [WIDTH*N_FEATURES-1:0]     w_mem [N_OUT];
    logic [WIDTH-1:0]                b_mem [N_OUT];
    logic [WIDTH*N_FEATURES-1:0]     row_w;
    logic [WIDTH-1:0]                row_b;
    logic [WIDTH-1:0]                cap_val;
    logic                            cfg_ok;
    logic                            cap_fire;
    logic                            last_cap;

    assign cfg_ok   = cfg_we && ({1'b0, cfg_addr} < N_OUT_A) &&
                      (state == S_IDLE || state == S_DONE);
    assign cap_fire = mac_valid_o && (state == S_ISSUE || state == S_DRAIN) &&
                      (cap_idx < N_OUT_I);
    assign last_cap = cap_fire && (cap_idx == LAST_I);

    // in_ready is also gated by rst_n so it drops the moment reset asserts.
    assign in_ready    = rst_n && (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign mac_valid_i = (state == S_ISSUE);
    assign mac_x_flat  = x_reg;
    assign mac_w_flat  = row_w;
    assign mac_b       = row_b;

`ifdef MAC_SEQ_RELU_EN
    assign cap_val = mac_yhat[WIDTH-1] ? '0 : mac_yhat;
`else
    assign cap_val = mac_yhat;
`endif

    // Select the weight row and bias for the neuron being issued.
    always_comb begin
        row_w = '0;
        row_b = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (issue_idx == IW'(k)) begin
                row_w = w_mem[k];
                row_b = b_mem[k];
            end
        end
    end

    // Sequencer: accept a vector, issue one neuron per cycle, wait for the
    // last result, then hold until the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            issue_idx <= '0;
            cap_idx   <= '0;
            x_reg     <= '0;
        end else begin
            if (cap_fire) begin
                cap_idx <= cap_idx + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x_flat;
                        issue_idx <= '0;
                        cap_idx   <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    issue_idx <= issue_idx + 1'b1;
                    if (issue_idx == LAST_I) begin
                        state <= last_cap ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_cap) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Weight/bias storage, written only while no vector is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                w_mem[k] <= '0;
                b_mem[k] <= '0;
            end
        end else if (cfg_ok) begin
            w_mem[cfg_addr] <= cfg_w_flat;
            b_mem[cfg_addr] <= cfg_b;
        end
    end

    // Rejected config writes report one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    // Collect mac results in issue order and accumulate the saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_flat  <= '0;
            sat_any <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            sat_any <= 1'b0;
        end else if (cap_fire) begin
            sat_any <= sat_any | mac_sat;
            for (int k = 0; k < N_OUT; k++) begin
                if (cap_idx == IW'(k)) begin
                    y_flat[k*WIDTH +: WIDTH] <= cap_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_layer_seq.sv
// Directed bench for mac_layer_seq with a behavioural Q16.16 mac attached.
// Three neurons are used so that an out-of-range config address exists.
module tb_mac_layer_seq;

    localparam int NF = 3;
    localparam int NO = 3;
    localparam int W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [W*NF-1:0]   cfg_w_flat;
    logic [W-1:0]      cfg_b;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [W*NF-1:0]   x_flat;
    logic              mac_valid_i;
    logic [W*NF-1:0]   mac_x_flat;
    logic [W*NF-1:0]   mac_w_flat;
    logic [W-1:0]      mac_b;
    logic              mac_valid_o = 1'b0;
    logic [W-1:0]      mac_yhat = '0;
    logic              mac_sat = 1'b0;
    logic              out_valid;
    logic              out_ready;
    logic [W*NO-1:0]   y_flat;
    logic              sat_any;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    logic [W*NF-1:0] row_w [NO];
    logic [W-1:0]    row_b [NO];
    logic [W*NF-1:0] x_main;
    logic [W*NF-1:0] x_big;
    logic [W*NF-1:0] w_sat;
    logic [W-1:0]    slot1_exp;

    mac_layer_seq #(.N_FEATURES(NF), .N_OUT(NO), .WIDTH(W), .FRACTION(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w_flat(cfg_w_flat),
        .cfg_b(cfg_b), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .x_flat(x_flat),
        .mac_valid_i(mac_valid_i), .mac_x_flat(mac_x_flat),
        .mac_w_flat(mac_w_flat), .mac_b(mac_b),
        .mac_valid_o(mac_valid_o), .mac_yhat(mac_yhat), .mac_sat(mac_sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_flat(y_flat), .sat_any(sat_any), .busy(busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural mac: sum of Q16.16 products plus bias, saturated to 32 bits.
    function automatic logic [W:0] mac_model(input logic [W*NF-1:0] xv,
                                             input logic [W*NF-1:0] wv,
                                             input logic [W-1:0] bv);
        longint acc;
        acc = longint'($signed(bv));
        for (int i = 0; i < NF; i++) begin
            acc = acc + ((longint'($signed(xv[i*W +: W])) *
                          longint'($signed(wv[i*W +: W]))) >>> 16);
        end
        if (acc > longint'(32'sh7FFFFFFF)) return {1'b1, 32'h7FFFFFFF};
        if (acc < -longint'(64'h80000000)) return {1'b1, 32'h80000000};
        return {1'b0, acc[31:0]};
    endfunction

    // The mac is not reset: stale results after a DUT reset must be ignored.
    always @(posedge clk) begin
        logic [W:0] r;
        r = mac_model(mac_x_flat, mac_w_flat, mac_b);
        mac_valid_o <= mac_valid_i;
        mac_yhat    <= r[W-1:0];
        mac_sat     <= r[W] & mac_valid_i;
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [W*NF-1:0] wv,
                             input logic [W-1:0] bv, input logic exp_err);
        cfg_we     = 1'b1;
        cfg_addr   = addr;
        cfg_w_flat = wv;
        cfg_b      = bv;
        tick();
        cfg_we = 1'b0;
        check_eq("cfg_err", 64'(cfg_err), 64'(exp_err));
    endtask

    task automatic send_vec(input logic [W*NF-1:0] xv);
        check_eq("in_ready_before_send", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        x_flat   = xv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("done_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic expect_vec(input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
    endtask

    task automatic check_slots();
        logic [W-1:0] e;
        for (int k = 0; k < NO; k++) begin
            e = exp_q.pop_front();
            check_eq($sformatf("y_slot%0d", k), 64'(y_flat[k*W +: W]), 64'(e));
        end
    endtask

    task automatic load_rows();
        for (int k = 0; k < NO; k++) cfg_write(2'(k), row_w[k], row_b[k], 1'b0);
    endtask

    initial begin
        // Q16.16 data: x=(1.0,0.5,-1.0); rows (2,4,-3)+0.25, (0.5,-1,8)-0.5, (1,1,1)+0
        x_main   = {32'hFFFF0000, 32'h00008000, 32'h00010000};
        row_w[0] = {32'hFFFD0000, 32'h00040000, 32'h00020000};
        row_b[0] = 32'h00004000;
        row_w[1] = {32'h00080000, 32'hFFFF0000, 32'h00008000};
        row_b[1] = 32'hFFFF8000;
        row_w[2] = {32'h00010000, 32'h00010000, 32'h00010000};
        row_b[2] = 32'h00000000;
        x_big    = {32'h03E80000, 32'h03E80000, 32'h7FFF0000};
        w_sat    = {32'h03E80000, 32'h03E80000, 32'h03E80000};
`ifdef MAC_SEQ_RELU_EN
        slot1_exp = 32'h00000000;
`else
        slot1_exp = 32'hFFF78000;
`endif

        // Reset
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_w_flat = '0; cfg_b = '0;
        in_valid = 1'b0; x_flat = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_cfg_err", 64'(cfg_err), 64'd0);
        check_eq("rst_mac_valid_i", 64'(mac_valid_i), 64'd0);
        check_eq("rst_y_low", y_flat[63:0], 64'd0);
        check_eq("rst_sat_any", 64'(sat_any), 64'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic layer and issue order, out_ready high
        load_rows();
        send_vec(x_main);
        for (int c = 0; c < NO; c++) begin
            check_eq($sformatf("issue%0d_valid", c), 64'(mac_valid_i), 64'd1);
            check_eq($sformatf("issue%0d_w", c), mac_w_flat[63:0], row_w[c][63:0]);
            check_eq($sformatf("issue%0d_w_hi", c), 64'(mac_w_flat[95:64]), 64'(row_w[c][95:64]));
            check_eq($sformatf("issue%0d_b", c), 64'(mac_b), 64'(row_b[c]));
            check_eq($sformatf("issue%0d_x", c), mac_x_flat[63:0], x_main[63:0]);
            check_eq($sformatf("issue%0d_in_ready", c), 64'(in_ready), 64'd0);
            tick();
        end
        check_eq("drain_mac_valid_i", 64'(mac_valid_i), 64'd0);
        check_eq("drain_out_valid", 64'(out_valid), 64'd0);
        check_eq("drain_busy", 64'(busy), 64'd1);
        tick();
        check_eq("latency_out_valid", 64'(out_valid), 64'd1);
        check_eq("basic_sat_any", 64'(sat_any), 64'd0);
        expect_vec(32'h00074000, slot1_exp, 32'h00008000);
        check_slots();
        tick();
        check_eq("basic_back_idle", 64'(busy), 64'd0);
        check_eq("basic_in_ready", 64'(in_ready), 64'd1);

        // Backpressure: hold out_ready low with a competing in_valid
        out_ready = 1'b0;
        send_vec(x_main);
        wait_done();
        in_valid = 1'b1;
        x_flat   = x_big;
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_slot0_stable", 64'(y_flat[31:0]), 64'h00074000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_released_busy", 64'(busy), 64'd0);
        check_eq("bp_released_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        expect_vec(32'h00074000, slot1_exp, 32'h00008000);
        check_slots();

        // Config rules: write during ISSUE and an out-of-range address
        send_vec(x_main);
        cfg_write(2'd0, w_sat, 32'h12345678, 1'b1);
        tick();
        check_eq("cfg_err_single_pulse", 64'(cfg_err), 64'd0);
        wait_done();
        expect_vec(32'h00074000, slot1_exp, 32'h00008000);
        check_slots();
        tick();
        cfg_write(2'd3, w_sat, 32'h12345678, 1'b1);
        tick();
        check_eq("cfg_err_range_pulse", 64'(cfg_err), 64'd0);
        send_vec(x_main);
        wait_done();
        expect_vec(32'h00074000, slot1_exp, 32'h00008000);
        check_slots();
        tick();

        // Saturation: row0 overflows; row1 = 16383.5-1000+8000-0.5 = 23383
        cfg_write(2'd0, w_sat, 32'h0, 1'b0);
        send_vec(x_big);
        wait_done();
        check_eq("sat_any_set", 64'(sat_any), 64'd1);
        check_eq("sat_slot0", 64'(y_flat[31:0]), 64'h7FFFFFFF);
        check_eq("sat_slot1", 64'(y_flat[63:32]), 64'h5B570000);
        tick();
        cfg_write(2'd0, row_w[0], row_b[0], 1'b0);
        send_vec(x_main);
        wait_done();
        check_eq("sat_any_cleared", 64'(sat_any), 64'd0);
        expect_vec(32'h00074000, slot1_exp, 32'h00008000);
        check_slots();
        tick();

        // Reset in the middle of ISSUE
        send_vec(x_main);
        check_eq("mid_issue_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
        check_eq("midrst_mac_valid_i", 64'(mac_valid_i), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("midrst_after_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_after_busy", 64'(busy), 64'd0);
        send_vec(x_main);
        wait_done();
        expect_vec(32'h0, 32'h0, 32'h0);
        check_slots();
        check_eq("midrst_sat_any", 64'(sat_any), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
